// File: rtl/impulse_sweep_ctrl_pkg.sv
// Shared types for the impulse sweep sequencer.
package impulse_sweep_ctrl_pkg;
  typedef enum logic {IDLE, RUN} sweep_state_t;
endpackage

// File: rtl/impulse_sweep_ctrl_if.sv
// AXI-Stream style output bundle carrying the impulse sample stream.
interface impulse_sweep_ctrl_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/impulse_sweep_ctrl_frame_phase_ctr.sv
// Sample / frame / phase counters of the sweep; exposes next-state values so
// the top level can register its outputs without a tready->tdata path.
module frame_phase_ctr #(
  parameter int MAX_CNT = 64,
  parameter int FRM_W   = 8,
  localparam int PW     = $clog2(MAX_CNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [PW-1:0]    load_pha,
  input  logic             advance,
  input  logic [FRM_W-1:0] frm_last,
  input  logic [PW-1:0]    pha_end,
  output logic [PW-1:0]    smp_nx,
  output logic [PW-1:0]    pha_nx,
  output logic             frame_done,
  output logic             sweep_end
);
  logic [PW-1:0]    smp_q, smp_d;
  logic [PW-1:0]    pha_q, pha_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic             last;

  assign last       = (smp_q == PW'(MAX_CNT - 1));
  assign frame_done = last && (frm_q == frm_last);
  assign sweep_end  = frame_done && (pha_q == pha_end);
  assign smp_nx     = smp_d;
  assign pha_nx     = pha_d;

  always_comb begin
    smp_d = smp_q;
    frm_d = frm_q;
    pha_d = pha_q;
    if (load) begin
      smp_d = '0;
      frm_d = '0;
      pha_d = load_pha;
    end else if (advance) begin
      // MAX_CNT is a power of two, so the sample and phase counters wrap naturally
      smp_d = smp_q + PW'(1);
      if (last) begin
        if (frm_q == frm_last) begin
          frm_d = '0;
          if (pha_q != pha_end) pha_d = pha_q + PW'(1);
        end else begin
          frm_d = frm_q + FRM_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q <= '0;
      frm_q <= '0;
      pha_q <= '0;
    end else begin
      smp_q <= smp_d;
      frm_q <= frm_d;
      pha_q <= pha_d;
    end
  end
endmodule

// File: rtl/impulse_sweep_ctrl.sv
// Impulse sweep sequencer: emits one impulse per M-sample frame, stepping its
// phase across a programmed range, with start/abort control and AXIS backpressure.
module impulse_sweep_ctrl
  import impulse_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int MAX_CNT = 64,
  parameter int FRM_W   = 8,
  localparam int PW     = $clog2(MAX_CNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PW-1:0]        phase_start,
  input  logic [PW-1:0]        phase_end,
  input  logic [FRM_W-1:0]     frames_per_phase,
  input  logic [WIDTH-1:0]     pulse_val,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [PW-1:0]        cur_phase,
  impulse_sweep_ctrl_if.master m_axis
);
  sweep_state_t     state_q, state_d;
  logic [PW-1:0]    cfg_end_q, cfg_end_d;
  logic [FRM_W-1:0] cfg_frm_last_q, cfg_frm_last_d;
  logic [WIDTH-1:0] cfg_pulse_q, cfg_pulse_d;
  logic             abort_req_q, abort_req_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic [WIDTH-1:0] tdata_q, tdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic [PW-1:0]    cur_phase_q, cur_phase_d;

  logic             load, xfer;
  logic [PW-1:0]    smp_nx, pha_nx;
  logic             frame_done, sweep_end;
  logic [WIDTH-1:0] pulse_src;

  assign load = (state_q == IDLE) && start;
  assign xfer = tvalid_q && m_axis.tready;

  frame_phase_ctr #(
    .MAX_CNT (MAX_CNT),
    .FRM_W   (FRM_W)
  ) u_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_pha   (phase_start),
    .advance    (xfer),
    .frm_last   (cfg_frm_last_q),
    .pha_end    (cfg_end_q),
    .smp_nx     (smp_nx),
    .pha_nx     (pha_nx),
    .frame_done (frame_done),
    .sweep_end  (sweep_end)
  );

  // Outputs are registered from the counters' next values, so a stall simply holds them
  assign pulse_src = load ? pulse_val : cfg_pulse_q;

  always_comb begin
    state_d        = state_q;
    cfg_end_d      = cfg_end_q;
    cfg_frm_last_d = cfg_frm_last_q;
    cfg_pulse_d    = cfg_pulse_q;
    abort_req_d    = abort_req_q;
    tvalid_d       = tvalid_q;
    tlast_d        = tlast_q;
    tdata_d        = tdata_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    aborted_d      = aborted_q;
    cur_phase_d    = cur_phase_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = RUN;
          cfg_end_d      = phase_end;
          cfg_frm_last_d = (frames_per_phase == '0) ? '0 : frames_per_phase - FRM_W'(1);
          cfg_pulse_d    = pulse_val;
          abort_req_d    = 1'b0;
          aborted_d      = 1'b0;
          busy_d         = 1'b1;
          tvalid_d       = 1'b1;
          tdata_d        = (smp_nx == pha_nx) ? pulse_src : '0;
          tlast_d        = (smp_nx == PW'(MAX_CNT - 1));
          cur_phase_d    = pha_nx;
        end
      end
      RUN: begin
        abort_req_d = abort_req_q || abort;
        if (xfer && frame_done && (sweep_end || abort_req_q || abort)) begin
          // A natural end takes precedence over a pending abort
          state_d   = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = !sweep_end;
          tvalid_d  = 1'b0;
          tlast_d   = 1'b0;
          tdata_d   = '0;
        end else if (xfer) begin
          tdata_d     = (smp_nx == pha_nx) ? pulse_src : '0;
          tlast_d     = (smp_nx == PW'(MAX_CNT - 1));
          cur_phase_d = pha_nx;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cfg_end_q      <= '0;
      cfg_frm_last_q <= '0;
      cfg_pulse_q    <= '0;
      abort_req_q    <= 1'b0;
      tvalid_q       <= 1'b0;
      tlast_q        <= 1'b0;
      tdata_q        <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      aborted_q      <= 1'b0;
      cur_phase_q    <= '0;
    end else begin
      state_q        <= state_d;
      cfg_end_q      <= cfg_end_d;
      cfg_frm_last_q <= cfg_frm_last_d;
      cfg_pulse_q    <= cfg_pulse_d;
      abort_req_q    <= abort_req_d;
      tvalid_q       <= tvalid_d;
      tlast_q        <= tlast_d;
      tdata_q        <= tdata_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      aborted_q      <= aborted_d;
      cur_phase_q    <= cur_phase_d;
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tdata  = tdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign cur_phase     = cur_phase_q;
endmodule
